// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - CIC decimator comb section; optional rounding via CIC_COMB_ROUND_EN
module cic_comb_decimator #(
  parameter int IW = 16,
  parameter int OW = 16,
  parameter int R  = 4,
  parameter int N  = 2,
  parameter int M  = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [IW-1:0] i_data,
  input  logic          i_ready,
  output logic [OW-1:0] o_data,
  output logic          o_ready
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

  logic [CW-1:0] count;
  logic [IW-1:0] dec_data;
  logic          dec_valid;

  logic [IW-1:0] dly      [N][M];
  logic [IW-1:0] stg_data [N];
  logic [N-1:0]  stg_valid;
  logic [IW-1:0] stg_in   [N];
  logic [N-1:0]  stg_in_valid;

  logic [IW-1:0] stg_last;
  logic [OW-1:0] out_next;

  // Decimation: count accepted samples and keep the R-th one
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count     <= '0;
      dec_data  <= '0;
      dec_valid <= 1'b0;
    end else begin
      dec_valid <= 1'b0;
      if (i_ready) begin
        if (count == CNT_LAST) begin
          count     <= '0;
          dec_data  <= i_data;
          dec_valid <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // Chain routing: stage 0 is fed by the decimation register, stage k by stage k-1
  always_comb begin
    stg_in[0]       = dec_data;
    stg_in_valid[0] = dec_valid;
    for (int k = 1; k < N; k++) begin
      stg_in[k]       = stg_data[k-1];
      stg_in_valid[k] = stg_valid[k-1];
    end
  end

  // Comb stages: y = x - x[n-M] with wrap-around; delay lines move only on valid input
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stg_valid <= '0;
      for (int k = 0; k < N; k++) begin
        stg_data[k] <= '0;
        for (int j = 0; j < M; j++) begin
          dly[k][j] <= '0;
        end
      end
    end else begin
      stg_valid <= stg_in_valid;
      for (int k = 0; k < N; k++) begin
        if (stg_in_valid[k]) begin
          stg_data[k] <= stg_in[k] - dly[k][M-1];
          dly[k][0]   <= stg_in[k];
          for (int j = 1; j < M; j++) begin
            dly[k][j] <= dly[k][j-1];
          end
        end
      end
    end
  end

  assign stg_last = stg_data[N-1];

  // Width reduction. Adding half an output LSB and truncating equals the top
  // bits plus the first discarded bit, wrapping in OW bits.
  generate
    if (OW < IW) begin : g_reduce
`ifdef CIC_COMB_ROUND_EN
      assign out_next = stg_last[IW-1:IW-OW] + OW'(stg_last[IW-OW-1]);
`else
      assign out_next = stg_last[IW-1:IW-OW];
`endif
    end else begin : g_full
      assign out_next = stg_last;
    end
  endgenerate

  // Output register: load on last-stage valid, strobe o_ready for one cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data  <= '0;
      o_ready <= 1'b0;
    end else begin
      o_ready <= stg_valid[N-1];
      if (stg_valid[N-1]) begin
        o_data <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb/tb_cic_comb_decimator.sv - self-checking bench for cic_comb_decimator
module tb_cic_comb_decimator;

`ifdef CIC_COMB_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  localparam int PR  [4] = '{4, 1, 3, 1};
  localparam int PN  [4] = '{2, 1, 3, 1};
  localparam int PM  [4] = '{1, 1, 2, 1};
  localparam int POW [4] = '{16, 8, 12, 16};

  logic        clk;
  logic        rst;
  logic [3:0]  rdy;
  logic [15:0] din [4];
  logic [15:0] od0;
  logic [7:0]  od1;
  logic [11:0] od2;
  logic [15:0] od3;
  logic [3:0]  ordy;
  logic [15:0] obs [4];

  cic_comb_decimator #(.IW(16), .OW(16), .R(4), .N(2), .M(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_data(din[0]), .i_ready(rdy[0]), .o_data(od0), .o_ready(ordy[0]));
  cic_comb_decimator #(.IW(16), .OW(8), .R(1), .N(1), .M(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_data(din[1]), .i_ready(rdy[1]), .o_data(od1), .o_ready(ordy[1]));
  cic_comb_decimator #(.IW(16), .OW(12), .R(3), .N(3), .M(2)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_data(din[2]), .i_ready(rdy[2]), .o_data(od2), .o_ready(ordy[2]));
  cic_comb_decimator #(.IW(16), .OW(16), .R(1), .N(1), .M(1)) dut_d (
    .i_clk(clk), .i_reset(rst), .i_data(din[3]), .i_ready(rdy[3]), .o_data(od3), .o_ready(ordy[3]));

  assign obs[0] = od0;
  assign obs[1] = {8'h00, od1};
  assign obs[2] = {4'h0, od2};
  assign obs[3] = od3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          acc [4];
  int          kn  [4];
  logic [15:0] ka    [4][1024];
  bit          exp_r [4][4096];
  logic [15:0] exp_d [4][4096];
  logic [15:0] last  [4];

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // N cascaded combs of delay M are the filter (1 - z^-M)^N on the kept samples
  function automatic logic [15:0] ref_out(input int i);
    int          n = kn[i] - 1;
    int          s = 0;
    int          term;
    int          idx;
    logic [15:0] y;
    for (int j = 0; j <= PN[i]; j++) begin
      idx = n - j * PM[i];
      if (idx >= 0) begin
        term = binom(PN[i], j) * int'(ka[i][idx]);
        s = (j % 2 == 1) ? s - term : s + term;
      end
    end
    y = 16'(s);
    if (POW[i] < 16) begin
      if (ROUND) y = y + (16'd1 << (15 - POW[i]));
      y = y >> (16 - POW[i]);
    end
    return y;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] rv,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3);
    @(negedge clk);
    rst = r; rdy = rv;
    din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        acc[i] = 0; kn[i] = 0; last[i] = '0;
        for (int t = cyc; t < cyc + 8; t++) exp_r[i][t] = 1'b0;
      end else if (rv[i]) begin
        acc[i]++;
        if (acc[i] == PR[i]) begin
          acc[i] = 0;
          ka[i][kn[i]] = din[i];
          kn[i]++;
          exp_r[i][cyc + PN[i] + 1] = 1'b1;
          exp_d[i][cyc + PN[i] + 1] = ref_out(i);
        end
      end
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      if (exp_r[i][cyc]) last[i] = exp_d[i][cyc];
      check($sformatf("o_ready[%0d]", i), {15'b0, ordy[i]}, {15'b0, exp_r[i][cyc]});
      check($sformatf("o_data[%0d]", i), obs[i], last[i]);
    end
    cyc++;
  endtask

  logic [15:0] s1;
  logic [15:0] s2;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b1; rdy = '0;
    for (int i = 0; i < 4; i++) begin
      din[i] = '0; acc[i] = 0; kn[i] = 0; last[i] = '0;
    end

    // reset held with traffic present
    repeat (3) step(1'b1, 4'hF, 16'h1234, 16'h1234, 16'h1234, 16'h1234);

    // step response on the default configuration
    repeat (7) step(1'b0, 4'b0101, 16'd5, 16'd0, 16'($urandom), 16'd0);
    check("step_first_strobe", {15'b0, ordy[0]}, 16'd1);
    check("step_first_value", obs[0], 16'd5);
    repeat (4) step(1'b0, 4'b0101, 16'd5, 16'd0, 16'($urandom), 16'd0);
    check("step_second_value", obs[0], 16'hFFFB);
    repeat (9) step(1'b0, 4'b0101, 16'd5, 16'd0, 16'($urandom), 16'd0);
    check("step_settled", obs[0], 16'd0);

    // wrap-around and rounding on the R=1, N=1 instances
    step(1'b0, 4'b1010, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF);
    step(1'b0, 4'b1010, 16'd0, 16'h8000, 16'd0, 16'h8000);
    step(1'b0, 4'b0010, 16'd0, 16'h0000, 16'd0, 16'd0);
    check("wrap_first", obs[3], 16'h7FFF);
    check("round_7fff", obs[1], ROUND ? 16'h0080 : 16'h007F);
    step(1'b0, 4'b0010, 16'd0, 16'h0180, 16'd0, 16'd0);
    check("wrap_second", obs[3], 16'h0001);
    step(1'b0, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
    step(1'b0, 4'b0000, 16'd0, 16'd0, 16'd0, 16'd0);
    check("round_0180", obs[1], ROUND ? 16'h0002 : 16'h0001);

    // gappy i_ready: every third cycle
    for (int t = 0; t < 40; t++)
      step(1'b0, (t % 3 == 0) ? 4'b0001 : 4'b0000, 16'($urandom), 16'd0, 16'($urandom), 16'd0);

    // end to end with a two-stage integrator fed by constant 1
    step(1'b1, 4'h0, 16'd0, 16'd0, 16'd0, 16'd0);
    s1 = '0; s2 = '0;
    for (int t = 0; t < 40; t++) begin
      s1 = s1 + 16'd1;
      s2 = s2 + s1;
      step(1'b0, 4'b0001, s2, 16'd0, 16'd0, 16'd0);
    end
    check("integrator_steady", obs[0], 16'd16);

    // random traffic on every instance, with a reset in the middle
    for (int t = 0; t < 400; t++) begin
      step(t == 200, 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
